// File: rtl/m_control.sv
// Sequencing FSM for the RV32M unit: decodes funct3 at issue, steps the
// multiply pipeline or the restoring divider, and flags writeback fix-ups.
package m_definitions;
  typedef enum logic [2:0] {R_KEEP, R_A, R_A_NEG, R_SUB_KEEP, R_MULT_LOWER} mux_r_t;
  typedef enum logic [1:0] {D_KEEP, D_B, D_B_NEG, D_SHR} mux_d_t;
  typedef enum logic [1:0] {Z_KEEP, Z_ZERO, Z_SHL_ADD, Z_MULT_UPPER} mux_z_t;
  typedef enum logic [1:0] {MA_ZERO, MA_R_UNSIGNED, MA_R_SIGNED} mux_ma_t;
  typedef enum logic [1:0] {MB_ZERO, MB_D_UNSIGNED, MB_D_SIGNED} mux_mb_t;
  typedef enum logic [1:0] {OVR_NONE, OVR_ONES, OVR_RS1, OVR_ZERO} override_t;
endpackage

module m_control
  import m_definitions::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_STEPS   = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] funct3,
  input  logic       rs1_sign,
  input  logic       rs2_sign,
  input  logic       rs2_zero,
  input  logic       rs1_min,
  input  logic       rs2_ones,
  input  logic       sub_neg,
  output mux_r_t     mux_R,
  output mux_d_t     mux_D,
  output mux_z_t     mux_Z,
  output mux_ma_t    mux_multA,
  output mux_mb_t    mux_multB,
  output logic       busy,
  output logic       done,
  output logic       result_sel,
  output logic       negate_result,
  output override_t  override
);

  localparam int CNT_MAX = (DIV_STEPS > MUL_LATENCY) ? DIV_STEPS : MUL_LATENCY;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_ISSUE, S_MUL_WAIT, S_MUL_CAPTURE, S_DIV_ITER, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    op;
  logic          neg_q, neg_r, div0, ovf;

  // The borrow is consumed by the datapath directly; the sequencer never needs it.
  logic sub_neg_unused;
  assign sub_neg_unused = sub_neg;

  // Issue-time decode of the live inputs; only meaningful while accepting.
  logic accept, sdiv_in, div0_in, ovf_in;
  assign accept  = (state == S_IDLE) && start;
  assign sdiv_in = funct3[2] & ~funct3[0];
  assign div0_in = funct3[2] & rs2_zero;
  assign ovf_in  = sdiv_in & rs1_min & rs2_ones;

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= 3'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        op    <= funct3;
        neg_q <= sdiv_in & (rs1_sign ^ rs2_sign);
        neg_r <= sdiv_in & rs1_sign;
        div0  <= div0_in;
        ovf   <= ovf_in;
      end
    end
  end

  // Multiplier operand selects follow the latched op for the whole multiply.
  mux_ma_t ma_op;
  mux_mb_t mb_op;
  assign ma_op = (op == 3'd1 || op == 3'd2) ? MA_R_SIGNED : MA_R_UNSIGNED;
  assign mb_op = (op == 3'd1) ? MB_D_SIGNED : MB_D_UNSIGNED;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mux_R         = R_KEEP;
    mux_D         = D_KEEP;
    mux_Z         = Z_KEEP;
    mux_multA     = MA_ZERO;
    mux_multB     = MB_ZERO;
    done          = 1'b0;
    result_sel    = 1'b0;
    negate_result = 1'b0;
    override      = OVR_NONE;

    case (state)
      S_IDLE: begin
        if (start) begin
          mux_Z = Z_ZERO;
          mux_R = (sdiv_in && rs1_sign) ? R_A_NEG : R_A;
          mux_D = (sdiv_in && rs2_sign) ? D_B_NEG : D_B;
          cnt_nxt = '0;
          if (!funct3[2])             state_nxt = S_MUL_ISSUE;
          else if (div0_in || ovf_in) state_nxt = S_DONE;
          else                        state_nxt = S_DIV_ITER;
        end
      end
      S_MUL_ISSUE: begin
        mux_multA = ma_op;
        mux_multB = mb_op;
        cnt_nxt   = '0;
        state_nxt = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        mux_multA = ma_op;
        mux_multB = mb_op;
        if (cnt == MUL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_MUL_CAPTURE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_MUL_CAPTURE: begin
        mux_multA = ma_op;
        mux_multB = mb_op;
        mux_R     = R_MULT_LOWER;
        mux_Z     = Z_MULT_UPPER;
        state_nxt = S_DONE;
      end
      S_DIV_ITER: begin
        mux_R = R_SUB_KEEP;
        mux_Z = Z_SHL_ADD;
        mux_D = D_SHR;
        if (cnt == DIV_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        done       = 1'b1;
        result_sel = (op == 3'd0) || (op[2:1] == 2'b11);
        // Special cases replace the result outright, so no negation applies.
        if (div0)     override = op[1] ? OVR_RS1 : OVR_ONES;
        else if (ovf) override = op[1] ? OVR_ZERO : OVR_RS1;
        if (!div0 && !ovf) begin
          if (op == 3'd4)      negate_result = neg_q;
          else if (op == 3'd6) negate_result = neg_r;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
